// File: rtl/pixel_ring_buffer.sv
// Circular pixel store: fills DEPTH pixels from a valid/ready load port, then
// exposes NUM_TAPS consecutive pixels and rotates one pixel per shift_en.
module pixel_ring_buffer #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 72,
   parameter int NUM_TAPS = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         load_valid,
   input  logic [DATA_W-1:0]            load_data,
   output logic                         load_ready,
   input  logic                         shift_en,
   output logic [NUM_TAPS*DATA_W-1:0]   tap_data,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   load_count,
   output logic [$clog2(DEPTH)-1:0]     rot_count,
   output logic                         rot_wrap
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ROT_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(DEPTH - 1);
   localparam logic [ROT_W-1:0] LAST_ROT  = ROT_W'(DEPTH - 1);

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_FULL = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic [DATA_W-1:0] entry [DEPTH];
   logic              load_accept;
   logic              rotate;
   logic              rot_last;

   // Load handshake: a pixel transfers on a rising edge where load_valid and
   // load_ready are both high and clear is low; load_ready does not depend on
   // load_valid, and a pixel offered while load_ready is low is simply ignored.

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_LOAD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (clear) begin
         state_next = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: if (load_valid && (load_count == LAST_LOAD)) state_next = ST_FULL;
            ST_FULL: state_next = ST_FULL;
            default: state_next = ST_LOAD;
         endcase
      end
   end

   always_comb begin
      load_ready  = (state == ST_LOAD);
      full        = (state == ST_FULL);
      load_accept = (state == ST_LOAD) && load_valid && !clear;
      rotate      = (state == ST_FULL) && shift_en && !clear;
      rot_last    = (rot_count == LAST_ROT);
   end

   // Loads and rotations share one shift path; only the value entering entry[0] differs.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry[i] <= '0;
         end
      end else if (load_accept || rotate) begin
         entry[0] <= load_accept ? load_data : entry[DEPTH-1];
         for (int i = 1; i < DEPTH; i++) begin
            entry[i] <= entry[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         load_count <= '0;
         rot_count  <= '0;
         rot_wrap   <= 1'b0;
      end else begin
         if (load_accept) begin
            load_count <= load_count + 1'b1;
         end
         if (rotate) begin
            rot_count <= rot_last ? '0 : rot_count + 1'b1;
         end
         rot_wrap <= rotate && rot_last;
      end
   end

   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
      assign tap_data[k*DATA_W +: DATA_W] = entry[DEPTH-1-k];
   end

endmodule

// File: tb/tb_pixel_ring_buffer.sv
// Bench for pixel_ring_buffer: a 72x8 two-tap instance and a 4x16 three-tap
// instance, checked every cycle against a load-order/rotation-offset model.
module tb_pixel_ring_buffer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance a: DATA_W=8, DEPTH=72, NUM_TAPS=2
   logic        a_clear, a_load_valid, a_load_ready, a_shift_en, a_full, a_rot_wrap;
   logic [7:0]  a_load_data;
   logic [15:0] a_tap_data;
   logic [6:0]  a_load_count;
   logic [6:0]  a_rot_count;

   // instance b: DATA_W=16, DEPTH=4, NUM_TAPS=3
   logic        b_clear, b_load_valid, b_load_ready, b_shift_en, b_full, b_rot_wrap;
   logic [15:0] b_load_data;
   logic [47:0] b_tap_data;
   logic [2:0]  b_load_count;
   logic [1:0]  b_rot_count;

   pixel_ring_buffer #(.DATA_W(8), .DEPTH(72), .NUM_TAPS(2)) dut_a (
      .clk(clk), .rst(rst), .clear(a_clear), .load_valid(a_load_valid),
      .load_data(a_load_data), .load_ready(a_load_ready), .shift_en(a_shift_en),
      .tap_data(a_tap_data), .full(a_full), .load_count(a_load_count),
      .rot_count(a_rot_count), .rot_wrap(a_rot_wrap)
   );

   pixel_ring_buffer #(.DATA_W(16), .DEPTH(4), .NUM_TAPS(3)) dut_b (
      .clk(clk), .rst(rst), .clear(b_clear), .load_valid(b_load_valid),
      .load_data(b_load_data), .load_ready(b_load_ready), .shift_en(b_shift_en),
      .tap_data(b_tap_data), .full(b_full), .load_count(b_load_count),
      .rot_count(b_rot_count), .rot_wrap(b_rot_wrap)
   );

   int tests = 0;
   int fails = 0;

   // Model: pixels in load order, count loaded, rotation offset, pending wrap.
   logic [15:0] pix [2][72];
   int          m_n [2];
   int          m_r [2];
   bit          m_wrap [2];

   function automatic int dep(int i);  return (i == 0) ? 72 : 4;  endfunction
   function automatic int ntap(int i); return (i == 0) ? 2 : 3;   endfunction
   function automatic int dw(int i);   return (i == 0) ? 8 : 16;  endfunction

   task automatic model_step(input int i, input logic r, input logic c, input logic lv,
                             input logic [15:0] ld, input logic sh);
      m_wrap[i] = 1'b0;
      if (r || c) begin
         m_n[i] = 0;
         m_r[i] = 0;
      end else if (m_n[i] < dep(i)) begin
         if (lv) begin
            pix[i][m_n[i]] = ld;
            m_n[i] = m_n[i] + 1;
         end
      end else if (sh) begin
         m_wrap[i] = (m_r[i] == dep(i) - 1);
         m_r[i] = (m_r[i] + 1) % dep(i);
      end
   endtask

   // While loading, tap k holds the pixel loaded DEPTH-k places before the
   // newest slot (zero if not loaded yet); once full, tap k is pixel (k+rot).
   function automatic logic [47:0] exp_taps(int i);
      logic [47:0] v;
      logic [47:0] px;
      int          j;
      v = '0;
      for (int k = 0; k < ntap(i); k++) begin
         if (m_n[i] < dep(i)) begin
            j  = m_n[i] - dep(i) + k;
            px = (j >= 0) ? {32'h0, pix[i][j]} : 48'h0;
         end else begin
            px = {32'h0, pix[i][(k + m_r[i]) % dep(i)]};
         end
         v = v | (px << (k * dw(i)));
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst, a_clear, a_load_valid, {8'h0, a_load_data}, a_shift_en);
      model_step(1, rst, b_clear, b_load_valid, b_load_data, b_shift_en);
   end

   always @(negedge clk) begin
      check("a_taps",       {32'h0, a_tap_data},   exp_taps(0));
      check("a_full",       {47'h0, a_full},       48'(m_n[0] == 72));
      check("a_load_ready", {47'h0, a_load_ready}, 48'(m_n[0] < 72));
      check("a_load_count", {41'h0, a_load_count}, 48'(m_n[0]));
      check("a_rot_count",  {41'h0, a_rot_count},  48'(m_r[0]));
      check("a_rot_wrap",   {47'h0, a_rot_wrap},   48'(m_wrap[0]));
      check("b_taps",       b_tap_data,            exp_taps(1));
      check("b_full",       {47'h0, b_full},       48'(m_n[1] == 4));
      check("b_load_ready", {47'h0, b_load_ready}, 48'(m_n[1] < 4));
      check("b_load_count", {45'h0, b_load_count}, 48'(m_n[1]));
      check("b_rot_count",  {46'h0, b_rot_count},  48'(m_r[1]));
      check("b_rot_wrap",   {47'h0, b_rot_wrap},   48'(m_wrap[1]));
   end

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic a_drive(input logic c, input logic lv, input logic [7:0] d, input logic sh);
      a_clear = c; a_load_valid = lv; a_load_data = d; a_shift_en = sh;
      cycle();
   endtask

   task automatic b_drive(input logic lv, input logic [15:0] d, input logic sh);
      b_load_valid = lv; b_load_data = d; b_shift_en = sh;
      cycle();
   endtask

   task automatic a_idle();
      a_clear = 1'b0; a_load_valid = 1'b0; a_load_data = '0; a_shift_en = 1'b0;
   endtask

   task automatic a_expect_empty(input string tag);
      check({tag, "_count"}, {41'h0, a_load_count}, 48'd0);
      check({tag, "_rot"},   {41'h0, a_rot_count},  48'd0);
      check({tag, "_full"},  {47'h0, a_full},       48'd0);
      check({tag, "_ready"}, {47'h0, a_load_ready}, 48'd1);
      check({tag, "_taps"},  {32'h0, a_tap_data},   48'd0);
   endtask

   logic [15:0] b_vals [4];
   int cnt;

   initial begin
      b_vals[0] = 16'hA1A1; b_vals[1] = 16'hB2B2; b_vals[2] = 16'hC3C3; b_vals[3] = 16'hD4D4;
      rst = 1'b1;
      a_idle();
      b_clear = 1'b0; b_load_valid = 1'b0; b_load_data = '0; b_shift_en = 1'b0;
      cycle();
      cycle();
      a_expect_empty("reset");
      check("reset_wrap", {47'h0, a_rot_wrap}, 48'd0);
      rst = 1'b0;

      // back-to-back load of 0..71
      for (int i = 0; i < 72; i++) begin
         if (i == 71) check("t1_ready_before_last", {47'h0, a_load_ready}, 48'd1);
         a_drive(1'b0, 1'b1, 8'(i), 1'b0);
      end
      a_idle();
      check("t1_ready",  {47'h0, a_load_ready}, 48'd0);
      check("t1_full",   {47'h0, a_full},       48'd1);
      check("t1_count",  {41'h0, a_load_count}, 48'd72);
      check("t1_taps",   {32'h0, a_tap_data},   48'h0100);

      // single rotation
      a_drive(1'b0, 1'b0, 8'h0, 1'b1);
      a_idle();
      check("t2_taps", {32'h0, a_tap_data},  48'h0201);
      check("t2_rot",  {41'h0, a_rot_count}, 48'd1);

      // complete the revolution
      for (int i = 0; i < 71; i++) a_drive(1'b0, 1'b0, 8'h0, 1'b1);
      a_idle();
      check("t3_wrap", {47'h0, a_rot_wrap},  48'd1);
      check("t3_rot",  {41'h0, a_rot_count}, 48'd0);
      check("t3_taps", {32'h0, a_tap_data},  48'h0100);
      cycle();
      check("t3_wrap_gone", {47'h0, a_rot_wrap}, 48'd0);

      // clear with a colliding load, then gapped load with shift_en noise
      a_drive(1'b1, 1'b1, 8'h77, 1'b1);
      a_idle();
      a_expect_empty("t4_clear");
      cnt = 0;
      for (int i = 0; cnt < 72; i++) begin
         if (i % 3 == 2) begin
            a_drive(1'b0, 1'b0, 8'hEE, 1'b1);
         end else begin
            a_drive(1'b0, 1'b1, 8'(cnt * 7 + 3), 1'(i % 2));
            cnt++;
         end
         if (cnt == 36 && i % 3 != 2) check("t4_half_count", {41'h0, a_load_count}, 48'd36);
      end
      a_idle();
      check("t4_count", {41'h0, a_load_count}, 48'd72);
      check("t4_taps",  {32'h0, a_tap_data},   48'h0A03);
      for (int i = 0; i < 5; i++) a_drive(1'b0, 1'b1, 8'hFF, 1'b0);
      a_idle();
      check("t4_hold_count", {41'h0, a_load_count}, 48'd72);
      check("t4_hold_taps",  {32'h0, a_tap_data},   48'h0A03);
      check("t4_hold_rot",   {41'h0, a_rot_count},  48'd0);

      // clear at load_count=30
      a_drive(1'b1, 1'b0, 8'h0, 1'b0);
      for (int i = 0; i < 30; i++) a_drive(1'b0, 1'b1, 8'(i + 100), 1'b0);
      check("t5_count30", {41'h0, a_load_count}, 48'd30);
      a_drive(1'b1, 1'b1, 8'h55, 1'b0);
      a_idle();
      a_expect_empty("t5_clear");

      // rst during rotation at rot_count=40
      for (int i = 0; i < 72; i++) a_drive(1'b0, 1'b1, 8'(i), 1'b0);
      for (int i = 0; i < 40; i++) a_drive(1'b0, 1'b0, 8'h0, 1'b1);
      a_idle();
      check("t5_rot40",  {41'h0, a_rot_count}, 48'd40);
      check("t5_taps40", {32'h0, a_tap_data},  48'h2928);
      rst = 1'b1;
      a_drive(1'b0, 1'b1, 8'h99, 1'b1);
      rst = 1'b0;
      a_idle();
      a_expect_empty("t5_rst");

      // small instance: 16-bit pixels, depth 4, three taps
      for (int i = 0; i < 4; i++) b_drive(1'b1, b_vals[i], 1'b0);
      b_load_valid = 1'b0;
      check("t6_full", {47'h0, b_full},    48'd1);
      check("t6_taps", b_tap_data,         48'hC3C3_B2B2_A1A1);
      b_drive(1'b1, 16'hFFFF, 1'b1);
      b_load_valid = 1'b0;
      check("t6_taps1", b_tap_data,        48'hD4D4_C3C3_B2B2);
      for (int i = 0; i < 3; i++) b_drive(1'b0, 16'h0, 1'b1);
      b_shift_en = 1'b0;
      check("t6_wrap",  {47'h0, b_rot_wrap}, 48'd1);
      check("t6_taps4", b_tap_data,          48'hC3C3_B2B2_A1A1);
      cycle();
      check("t6_wrap_gone", {47'h0, b_rot_wrap}, 48'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
